// File: rtl/maxpool1.sv
// maxpool1: 2x2/stride-2 max pooling of a CH-channel IN_DIM x IN_DIM map, one output pixel per clock.
// Latency: map accepted at edge E0, finished rises after edge E0 + CH*OUT_DIM*OUT_DIM.
// Backpressure: a map is accepted only in IDLE; finished and pooled_out hold until out_ack.
// Define MAXPOOL1_SIGNED_EN for two's-complement pixel comparison (unsigned otherwise).
module maxpool1 #(
    parameter  int CH      = 2,
    parameter  int IN_DIM  = 28,
    parameter  int PIX_W   = 1,
    localparam int OUT_DIM = IN_DIM / 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [CH*IN_DIM*IN_DIM*PIX_W-1:0]  featuremap_in,
    input  logic                               in_valid,
    output logic                               in_ack,
    output logic [CH*OUT_DIM*OUT_DIM*PIX_W-1:0] pooled_out,
    output logic                               finished,
    input  logic                               out_ack
);
    localparam int IN_BITS  = CH * IN_DIM * IN_DIM * PIX_W;
    localparam int OUT_BITS = CH * OUT_DIM * OUT_DIM * PIX_W;
    localparam int C_W      = (CH > 1) ? $clog2(CH) : 1;
    localparam int D_W      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam int IB_W     = (IN_BITS > 1) ? $clog2(IN_BITS) : 1;
    localparam int OB_W     = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_POOL = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state;
    logic [IN_BITS-1:0] buf_q;
    logic [C_W-1:0]     c_cnt;
    logic [D_W-1:0]     r_cnt;
    logic [D_W-1:0]     k_cnt;
    logic               last_c;
    logic               last_r;
    logic               last_k;

    logic [31:0]        win_base;
    logic [31:0]        out_lin;
    logic [IB_W-1:0]    off_00;
    logic [IB_W-1:0]    off_01;
    logic [IB_W-1:0]    off_10;
    logic [IB_W-1:0]    off_11;
    logic [OB_W-1:0]    out_off;
    logic [PIX_W-1:0]   p00;
    logic [PIX_W-1:0]   p01;
    logic [PIX_W-1:0]   p10;
    logic [PIX_W-1:0]   p11;
    logic [PIX_W-1:0]   win_max;

    function automatic logic [PIX_W-1:0] pix_max(input logic [PIX_W-1:0] a,
                                                 input logic [PIX_W-1:0] b);
`ifdef MAXPOOL1_SIGNED_EN
        return ($signed(a) > $signed(b)) ? a : b;
`else
        return (a > b) ? a : b;
`endif
    endfunction

    assign last_c = (c_cnt == C_W'(CH - 1));
    assign last_r = (r_cnt == D_W'(OUT_DIM - 1));
    assign last_k = (k_cnt == D_W'(OUT_DIM - 1));

    // Top-left corner of the current 2x2 window, in bits; the other three follow.
    always_comb begin
        win_base = ((32'(c_cnt) * IN_DIM + 32'(r_cnt) * 2) * IN_DIM + 32'(k_cnt) * 2) * PIX_W;
        out_lin  = ((32'(c_cnt) * OUT_DIM + 32'(r_cnt)) * OUT_DIM + 32'(k_cnt)) * PIX_W;
        off_00   = IB_W'(win_base);
        off_01   = IB_W'(win_base + PIX_W);
        off_10   = IB_W'(win_base + IN_DIM * PIX_W);
        off_11   = IB_W'(win_base + (IN_DIM + 1) * PIX_W);
        out_off  = OB_W'(out_lin);
        p00      = buf_q[off_00 +: PIX_W];
        p01      = buf_q[off_01 +: PIX_W];
        p10      = buf_q[off_10 +: PIX_W];
        p11      = buf_q[off_11 +: PIX_W];
        win_max  = pix_max(pix_max(p00, p01), pix_max(p10, p11));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            in_ack     <= 1'b0;
            finished   <= 1'b0;
            pooled_out <= '0;
            buf_q      <= '0;
            c_cnt      <= '0;
            r_cnt      <= '0;
            k_cnt      <= '0;
        end else begin
            in_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        buf_q  <= featuremap_in;
                        in_ack <= 1'b1;
                        c_cnt  <= '0;
                        r_cnt  <= '0;
                        k_cnt  <= '0;
                        state  <= S_POOL;
                    end
                end
                S_POOL: begin
                    pooled_out[out_off +: PIX_W] <= win_max;
                    if (!last_k) begin
                        k_cnt <= k_cnt + D_W'(1);
                    end else begin
                        k_cnt <= '0;
                        if (!last_r) begin
                            r_cnt <= r_cnt + D_W'(1);
                        end else begin
                            r_cnt <= '0;
                            c_cnt <= last_c ? '0 : c_cnt + C_W'(1);
                        end
                    end
                    if (last_k && last_r && last_c) begin
                        state    <= S_DONE;
                        finished <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ack) begin
                        state    <= S_IDLE;
                        finished <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_maxpool1.sv
// Bench for maxpool1: default 2x28x28x1 instance plus a 1x4x4x8 instance, checked against a pooling model.
module tb_maxpool1;
    localparam int IN_BITS  = 1568;
    localparam int OUT_BITS = 392;
    localparam int IN8      = 128;
    localparam int OUT8     = 32;
    localparam int LAT      = 392;
    localparam int LAT8     = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [IN_BITS-1:0]  featuremap_in;
    logic                in_valid;
    logic                in_ack;
    logic [OUT_BITS-1:0] pooled_out;
    logic                finished;
    logic                out_ack;

    logic [IN8-1:0]      fm8;
    logic                in_valid8;
    logic                in_ack8;
    logic [OUT8-1:0]     pooled8;
    logic                finished8;
    logic                out_ack8;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    maxpool1 u_dut (
        .clk(clk), .reset(reset), .featuremap_in(featuremap_in), .in_valid(in_valid),
        .in_ack(in_ack), .pooled_out(pooled_out), .finished(finished), .out_ack(out_ack)
    );

    maxpool1 #(.CH(1), .IN_DIM(4), .PIX_W(8)) u_dut8 (
        .clk(clk), .reset(reset), .featuremap_in(fm8), .in_valid(in_valid8),
        .in_ack(in_ack8), .pooled_out(pooled8), .finished(finished8), .out_ack(out_ack8)
    );

    task automatic check(input string tag, input logic [399:0] got, input logic [399:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference pooling: read each window as integers, take the arithmetic maximum.
    function automatic logic [399:0] pool_ref(input logic [1567:0] m, input int ch,
                                              input int din, input int pw);
        logic [399:0] res;
        int dout;
        res  = '0;
        dout = din / 2;
        for (int c = 0; c < ch; c++)
            for (int r = 0; r < dout; r++)
                for (int k = 0; k < dout; k++) begin
                    int best;
                    int o;
                    best = -(1 << 30);
                    for (int dr = 0; dr < 2; dr++)
                        for (int dk = 0; dk < 2; dk++) begin
                            int idx;
                            int v;
                            idx = ((c * din + 2 * r + dr) * din + 2 * k + dk) * pw;
                            v = 0;
                            for (int b = 0; b < pw; b++)
                                if (m[idx + b]) v += (1 << b);
`ifdef MAXPOOL1_SIGNED_EN
                            if (v >= (1 << (pw - 1))) v -= (1 << pw);
`endif
                            if (v > best) best = v;
                        end
                    o = (c * dout + r) * dout + k;
                    for (int b = 0; b < pw; b++) res[o * pw + b] = best[b];
                end
        return res;
    endfunction

    function automatic logic [1567:0] sparse_map(input int one_in);
        logic [1567:0] m;
        for (int i = 0; i < IN_BITS; i++) m[i] = ($urandom_range(0, one_in - 1) == 0);
        return m;
    endfunction

    function automatic logic [1567:0] byte_map();
        logic [1567:0] m;
        m = '0;
        for (int i = 0; i < IN8 / 8; i++) m[i * 8 +: 8] = 8'($urandom_range(0, 255));
        return m;
    endfunction

    task automatic start_job(input bit sel, input logic [1567:0] m);
        if (sel) begin fm8 = m[IN8-1:0]; in_valid8 = 1'b1; end
        else begin featuremap_in = m; in_valid = 1'b1; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_valid8 = 1'b0;
        check(sel ? "ack8_high" : "ack_high", sel ? in_ack8 : in_ack, 1);
        featuremap_in = sparse_map(2);
        fm8 = ~fm8;
    endtask

    task automatic wait_fin(input bit sel, output int n);
        n = 0;
        while (((sel ? finished8 : finished) !== 1'b1) && n < 2000) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) check(sel ? "ack8_one_cycle" : "ack_one_cycle", sel ? in_ack8 : in_ack, 0);
        end
    endtask

    task automatic do_ack(input bit sel);
        if (sel) out_ack8 = 1'b1; else out_ack = 1'b1;
        @(posedge clk); #1;
        out_ack = 1'b0;
        out_ack8 = 1'b0;
        check(sel ? "fin8_drop" : "fin_drop", sel ? finished8 : finished, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1567:0] m;
        logic [1567:0] m2;
        logic [399:0]  exp;
        logic [399:0]  exp2;
        int n;

        reset = 1'b0; in_valid = 1'b1; out_ack = 1'b0; featuremap_in = sparse_map(2);
        fm8 = '1; in_valid8 = 1'b1; out_ack8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ack", in_ack, 0);
        check("rst_finished", finished, 0);
        check("rst_pooled", pooled_out, 0);
        check("rst_pooled8", pooled8, 0);
        in_valid = 1'b0; in_valid8 = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        check("no_accept_idle", in_ack, 0);

        // Two isolated ones: ch0 (0,1,1) and ch1 (1,27,26)
        m = '0; m[29] = 1'b1; m[1566] = 1'b1;
        exp = pool_ref(m, 2, 28, 1);
        start_job(0, m);
        wait_fin(0, n);
        check("lat_single", n, LAT);
        check("pool_single", pooled_out, exp);
`ifndef MAXPOOL1_SIGNED_EN
        exp2 = '0; exp2[0] = 1'b1; exp2[391] = 1'b1;
        check("pool_single_bits", pooled_out, exp2);
`endif

        // Hold in DONE with a new map already offered
        m2 = sparse_map(5);
        featuremap_in = m2; in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            check("hold_fin", finished, 1);
            check("hold_pooled", pooled_out, exp);
        end
        out_ack = 1'b1;
        @(posedge clk); #1;
        out_ack = 1'b0;
        check("fin_drop_hold", finished, 0);
        check("no_accept_on_ack_edge", in_ack, 0);
        @(posedge clk); #1;
        check("accept_after_done", in_ack, 1);
        in_valid = 1'b0;
        featuremap_in = sparse_map(2);

        // Spurious out_ack and in_valid while pooling
        n = 0;
        while (finished !== 1'b1 && n < 2000) begin
            out_ack  = (n >= 10 && n < 20);
            in_valid = (n >= 10 && n < 20);
            @(posedge clk); #1;
            n++;
            if (n >= 10 && n <= 21) check("no_ack_in_pool", in_ack, 0);
        end
        out_ack = 1'b0; in_valid = 1'b0;
        check("lat_second", n, LAT);
        check("pool_second", pooled_out, pool_ref(m2, 2, 28, 1));
        do_ack(0);

        // Abort mid-job
        start_job(0, sparse_map(3));
        repeat (99) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort_in_ack", in_ack, 0);
        check("abort_finished", finished, 0);
        check("abort_pooled", pooled_out, 0);
        reset = 1'b1;
        m = sparse_map(6);
        start_job(0, m);
        wait_fin(0, n);
        check("lat_after_abort", n, LAT);
        check("pool_after_abort", pooled_out, pool_ref(m, 2, 28, 1));
        do_ack(0);

        for (int j = 0; j < 3; j++) begin
            m = sparse_map(4 + 4 * j);
            start_job(0, m);
            wait_fin(0, n);
            check("lat_rand", n, LAT);
            check("pool_rand", pooled_out, pool_ref(m, 2, 28, 1));
            do_ack(0);
        end

        // 8-bit instance: window 0 = {3,9,7,1}, others {80,01,00,00}
        m = '0;
        m[0 * 8 +: 8] = 8'd3; m[1 * 8 +: 8] = 8'd9; m[4 * 8 +: 8] = 8'd7; m[5 * 8 +: 8] = 8'd1;
        m[2 * 8 +: 8]  = 8'h80; m[3 * 8 +: 8]  = 8'h01;
        m[8 * 8 +: 8]  = 8'h80; m[9 * 8 +: 8]  = 8'h01;
        m[10 * 8 +: 8] = 8'h80; m[11 * 8 +: 8] = 8'h01;
        start_job(1, m);
        wait_fin(1, n);
        check("lat8", n, LAT8);
`ifdef MAXPOOL1_SIGNED_EN
        exp2 = 400'h01010109;
`else
        exp2 = 400'h80808009;
`endif
        check("pool8_table", pooled8, exp2);
        check("pool8_model", pooled8, pool_ref(m, 1, 4, 8));
        do_ack(1);

        for (int j = 0; j < 4; j++) begin
            m = byte_map();
            start_job(1, m);
            wait_fin(1, n);
            check("lat8_rand", n, LAT8);
            check("pool8_rand", pooled8, pool_ref(m, 1, 4, 8));
            do_ack(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/maxpool1.md
Name: maxpool1

Overview:
- First 2x2/stride-2 max-pooling stage of the LeNet datapath, directly downstream of the first convolution layer.
- Accepts the convolution layer's complete two-channel 28x28 feature map through a valid/reply handshake and buffers it internally.
- Reduces each channel to 14x14, one output pixel per clock, and presents the pooled map to the next layer through a finished/ack handshake.

Parameters:
- CH, 2, number of feature-map channels.
- IN_DIM, 28, input side length (must be even).
- PIX_W, 1, bits per pixel.
- OUT_DIM, IN_DIM/2, output side length (derived, not overridden).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous reset, active-low (0 = reset), sampled on rising clk.
- featuremap_in  input  CH*IN_DIM*IN_DIM*PIX_W  conv output map (1568 bits at defaults).
- in_valid  input  1  upstream map valid; driven by the conv layer's finished.
- in_ack  output  1  one-cycle reply to upstream; drives the conv layer's have_received_reply_from_next_device.
- pooled_out  output  CH*OUT_DIM*OUT_DIM*PIX_W  pooled map (392 bits at defaults).
- finished  output  1  pooled_out valid; held until out_ack.
- out_ack  input  1  downstream reply that the pooled map has been taken.

Behaviour:
- Bit layout, both buses: pixel (c,r,k) at [((c*D+r)*D+k)*PIX_W +: PIX_W], with D = IN_DIM or OUT_DIM.
- Reset (reset=0 at an edge):
  - state=IDLE; in_ack=0; finished=0; pooled_out=0; internal buffer=0; counters=0.
  - Applies from any state, including mid-POOL; the partial result is discarded.
- States: IDLE, POOL, DONE. Encoding is free.
- IDLE:
  - On an edge with in_valid=1: copy featuremap_in into the internal buffer, in_ack<=1, clear counters, go to POOL.
  - Otherwise stay; in_ack<=0.
- in_ack is registered, high exactly one cycle, the cycle after acceptance.
- POOL:
  - Each edge computes output pixel (c,r,k) = max of buffer pixels (c,2r,2k), (c,2r,2k+1), (c,2r+1,2k), (c,2r+1,2k+1) and writes it into pooled_out.
  - Comparison is unsigned by default. With PIX_W=1 this reduces to an OR.
  - Counter order: k fastest, then r, then c.
  - On the edge writing (CH-1, OUT_DIM-1, OUT_DIM-1), go to DONE and set finished<=1.
  - in_valid is ignored in POOL and in DONE; the buffer is never overwritten mid-job.
- Latency: acceptance at edge E0 → finished high after edge E0+CH*OUT_DIM*OUT_DIM (E0+392 at defaults).
- DONE:
  - finished=1 and pooled_out held stable.
  - On an edge with out_ack=1: go to IDLE, finished<=0.
  - pooled_out keeps its value in IDLE until the next job's first POOL write.
  - If in_valid=1 and out_ack=1 on the same DONE edge: only the return to IDLE occurs. The new map is accepted no earlier than the following edge.
- out_ack outside DONE is ignored.
- Back-to-back jobs: the minimum acceptance spacing is CH*OUT_DIM*OUT_DIM+2 cycles.

Optional Feature:
- Macro: MAXPOOL1_SIGNED_EN.
- Defined: pixels are two's-complement PIX_W-bit values; the max uses signed comparison (e.g. 8'h80 < 8'h01).
- Undefined: unsigned comparison (8'h80 > 8'h01).
- No ports or timing change in either case.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1 → in_ack=0, finished=0, pooled_out=0; no acceptance until reset=1.
- Single-bit map, defaults:
  - Stimulus: ch0 pixel (0,1,1)=1, ch1 pixel (1,27,26)=1, all others 0; pulse in_valid at E0.
  - Expected: in_ack high one cycle after E0; finished rises after E0+392.
  - Expected: pooled_out bits 0 and 391 =1, all others 0.
- Handshake hold: leave out_ack=0 for 50 cycles after finished → finished and pooled_out stable. Raise out_ack → finished=0 the next cycle. Keep in_valid=1 throughout → the second job is accepted one edge after the return to IDLE.
- Mid-job abort: reset=0 at E0+100 → all outputs 0. A new job started afterwards produces the correct map with no residue.
- PIX_W=8, CH=1, IN_DIM=4:
  - Stimulus: window 0 = {3,9,7,1}; windows 1-3 = {8'h80,8'h01,0,0}.
  - Expected without the macro: outputs {9,8'h80,8'h80,8'h80}.
  - Expected with MAXPOOL1_SIGNED_EN: outputs {9,1,1,1}.
  - Latency 4 cycles.
- Spurious inputs: out_ack=1 during POOL → no effect. A new in_valid pulse during POOL → not accepted, buffer unchanged, no in_ack.
